gigatron_input_injector: RTL



---
 rtl/gigatron_input_injector.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gigatron_input_injector.sv
// rtl/gigatron_input_injector.sv - frame-synchronous keystroke/joystick injector for the Gigatron input register
`timescale 1ns/1ps

module gigatron_input_injector #(
  parameter int HOLD_FRAMES  = 2,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 5,
  parameter int REPEAT_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_code,
  input  logic [7:0] joy_n,
  input  logic       frame_stb,
  output logic [7:0] in_byte,
  output logic       key_active
);

  localparam logic [7:0] KEY_NONE  = 8'hFF;
  localparam logic [7:0] HOLD_CNT  = HOLD_FRAMES[7:0];
  localparam logic [7:0] DELAY_CNT = REPEAT_DELAY[7:0];
  localparam logic [7:0] RATE_CNT  = REPEAT_RATE[7:0];
  localparam logic       RPT_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    DELAY   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] code_q;
  logic       first_rep;

  // The decrement that would take the counter to zero is the exit strobe.
  logic       cnt_last;
  logic       same_key;
  assign cnt_last = (frame_cnt <= 8'd1);
  assign same_key = (ascii_code == code_q);

  // Stroke sequencer; outputs are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= 8'd0;
      code_q     <= KEY_NONE;
      first_rep  <= 1'b1;
      in_byte    <= KEY_NONE;
      key_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_stb && (ascii_code != KEY_NONE)) begin
            code_q     <= ascii_code;
            frame_cnt  <= HOLD_CNT;
            first_rep  <= 1'b1;
            state      <= PRESS;
            in_byte    <= ascii_code;
            key_active <= 1'b1;
          end else begin
            in_byte    <= joy_n;
            key_active <= 1'b0;
          end
        end

        PRESS: begin
          in_byte    <= code_q;
          key_active <= 1'b1;
          if (frame_stb) begin
            if (cnt_last) begin
              in_byte    <= KEY_NONE;
              key_active <= 1'b0;
              if (RPT_ON && same_key) begin
                state     <= DELAY;
                frame_cnt <= first_rep ? DELAY_CNT : RATE_CNT;
                first_rep <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        DELAY: begin
          in_byte    <= KEY_NONE;
          key_active <= 1'b0;
          if (frame_stb) begin
            if (!same_key) begin
              state <= RELEASE;
            end else if (cnt_last) begin
              frame_cnt  <= HOLD_CNT;
              state      <= PRESS;
              in_byte    <= code_q;
              key_active <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        RELEASE: begin
          in_byte    <= KEY_NONE;
          key_active <= 1'b0;
          if (frame_stb && !same_key) begin
            state   <= IDLE;
            in_byte <= joy_n;
          end
        end

        default: begin
          state      <= IDLE;
          in_byte    <= KEY_NONE;
          key_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
